// File: rtl/spi_master_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spi_master_ctrl : serialises host RAM commands into 11-bit SPI slave frames
// Revision 1.0
// ============================================================================
module spi_master_ctrl #(
   parameter int RD_TURNAROUND = 2,
   parameter int IDLE_GAP      = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       MOSI,
   input  logic       MISO,
   output logic       SS_n
);

   localparam logic [3:0] TURN_LOAD = 4'(RD_TURNAROUND - 1);
   localparam logic [3:0] GAP_LOAD  = 4'(IDLE_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_SHIFT = 3'd2,
      S_TURN  = 3'd3,
      S_RECV  = 3'd4,
      S_END   = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [10:0] frame_q, frame_d;
   logic [1:0]  cmd_q, cmd_d;
   logic        ss_n_q, ss_n_d;
   logic        mosi_q, mosi_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        busy_q, busy_d;
   logic        recv_q, recv_d;
   logic        last_q, last_d;
   logic [6:0]  shreg_q, shreg_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic        accept;

   always_comb begin
      accept  = cmd_valid && cmd_ready_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      cmd_d   = cmd_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               frame_d = {cmd[1], cmd, cmd_data};
               cmd_d   = cmd;
               state_d = S_START;
            end
         end
         S_START: begin
            state_d = S_SHIFT;
            cnt_d   = 4'd10;
         end
         S_SHIFT: begin
            frame_d = {frame_q[9:0], 1'b0};
            if (cnt_q == 4'd0) begin
               if (cmd_q == 2'b11) begin
                  state_d = S_TURN;
                  cnt_d   = TURN_LOAD;
               end else begin
                  state_d = S_END;
                  cnt_d   = GAP_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_TURN: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RECV;
               cnt_d   = 4'd7;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RECV: begin
            if (cnt_q == 4'd0) begin
               state_d = S_END;
               cnt_d   = GAP_LOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_END: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Pins and handshake lag the state by one cycle, all from flops.
      ss_n_d      = !((state_q == S_START) || (state_q == S_SHIFT) ||
                      (state_q == S_TURN)  || (state_q == S_RECV));
      mosi_d      = (state_q == S_SHIFT) && frame_q[10];
      cmd_ready_d = (state_q == S_IDLE) && !accept;
      busy_d      = !cmd_ready_d;
      recv_d      = (state_q == S_RECV);
      last_d      = (state_q == S_RECV) && (cnt_q == 4'd0);
      shreg_d     = recv_q ? {shreg_q[5:0], MISO} : shreg_q;
      rsp_valid_d = last_q;
      rsp_data_d  = last_q ? {shreg_q, MISO} : rsp_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= 4'd0;
         frame_q     <= 11'd0;
         cmd_q       <= 2'b00;
         ss_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         recv_q      <= 1'b0;
         last_q      <= 1'b0;
         shreg_q     <= 7'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
      end else begin
         cnt_q       <= cnt_d;
         frame_q     <= frame_d;
         cmd_q       <= cmd_d;
         ss_n_q      <= ss_n_d;
         mosi_q      <= mosi_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         recv_q      <= recv_d;
         last_q      <= last_d;
         shreg_q     <= shreg_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign SS_n      = ss_n_q;
   assign MOSI      = mosi_q;
   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire
